// File: rtl/t02_mem_arbiter_if.sv
// Requester-side and bus-side signals of the N-channel memory arbiter.
// slave is the arbiter's view; master is the requesters/bus-model view.
interface t02_mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int SW = DW / 8;

  logic                 en;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    wen;
  logic [NUM_CH*AW-1:0] addr;
  logic [NUM_CH*DW-1:0] wdata;
  logic [NUM_CH*SW-1:0] sel;
  logic [NUM_CH-1:0]    ready;
  logic                 err;
  logic [DW-1:0]        rdata;
  logic [NUM_CH-1:0]    grant;

  logic                 Ren;
  logic                 Wen;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore;
  logic [SW-1:0]        ramsel;
  logic [DW-1:0]        ramload;
  logic                 busy_o;

  modport slave (
    input  en, req, wen, addr, wdata, sel, ramload, busy_o,
    output ready, err, rdata, grant, Ren, Wen, ramaddr, ramstore, ramsel
  );

  modport master (
    output en, req, wen, addr, wdata, sel, ramload, busy_o,
    input  ready, err, rdata, grant, Ren, Wen, ramaddr, ramstore, ramsel
  );
endinterface

// File: rtl/t02_mem_arbiter.sv
// N-channel arbiter in front of a single shared RAM bus: fixed-priority or
// round-robin selection, latched request, bus-acceptance timeout with error.
module t02_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               CLK,
  input  logic               nRST,
  t02_mem_arbiter_if.slave   bus
);
  localparam int SW = DW / 8;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              wen_q, wen_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic              timeout;
  logic              win_valid;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic              active;

  logic [AW-1:0] addr_arr  [NUM_CH];
  logic [DW-1:0] wdata_arr [NUM_CH];
  logic [SW-1:0] sel_arr   [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*AW +: AW];
      assign wdata_arr[gi] = bus.wdata[gi*DW +: DW];
      assign sel_arr[gi]   = bus.sel[gi*SW +: SW];
    end
  endgenerate

  // Winner search; round-robin rotates the starting point to the pointer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) cand = PW'((int'(ptr_q) + k) % NUM_CH);
      else               cand = PW'(k);
      if (!win_valid && bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      ready_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:  if (bus.en && win_valid) state_d = ISSUE;
      ISSUE: begin
        if (bus.busy_o) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (TIMEOUT_CYC != 0 && cnt_d == CW'(TIMEOUT_CYC)) begin
            state_d = DONE;
            timeout = 1'b1;
          end
        end
      end
      WAIT:  if (!bus.busy_o) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, pointer update and registered completion outputs.
  always_comb begin
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wen_d   = wen_q;
    ptr_d   = ptr_q;
    ready_d = '0;
    err_d   = timeout;
    rdata_d = rdata_q;
    if (state_q == IDLE && state_d == ISSUE) begin
      gnt_d   = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
      addr_d  = addr_arr[win_idx];
      wdata_d = wdata_arr[win_idx];
      sel_d   = sel_arr[win_idx];
      wen_d   = bus.wen[win_idx];
      if (ARB_MODE == 1)
        ptr_d = (win_idx == PW'(NUM_CH - 1)) ? '0 : win_idx + PW'(1);
    end
    if (state_q != DONE && state_d == DONE) ready_d = gnt_q;
    if (timeout)
      rdata_d = '0;
    else if (state_q == WAIT && !bus.busy_o && !wen_q)
      rdata_d = bus.ramload;
  end

  logic              ren_o, wen_o;
  logic [NUM_CH-1:0] grant_o;
  logic [AW-1:0]     ramaddr_o;
  logic [DW-1:0]     ramstore_o;
  logic [SW-1:0]     ramsel_o;

  always_comb begin
    active     = (state_q == ISSUE) || (state_q == WAIT);
    ren_o      = active & ~wen_q;
    wen_o      = active & wen_q;
    grant_o    = active ? gnt_q   : '0;
    ramaddr_o  = active ? addr_q  : '0;
    ramstore_o = active ? wdata_q : '0;
    ramsel_o   = active ? sel_q   : '0;
  end

  assign bus.Ren      = ren_o;
  assign bus.Wen      = wen_o;
  assign bus.grant    = grant_o;
  assign bus.ramaddr  = ramaddr_o;
  assign bus.ramstore = ramstore_o;
  assign bus.ramsel   = ramsel_o;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter with a short timeout
// and a 3-channel round-robin arbiter, driven by hand-computed vectors.
module tb_t02_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  t02_mem_arbiter_if #(.NUM_CH(2), .AW(32), .DW(32)) ifa ();
  t02_mem_arbiter_if #(.NUM_CH(3), .AW(32), .DW(32)) ifb ();

  t02_mem_arbiter #(.NUM_CH(2), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT_CYC(4)) dut_a (
    .CLK(CLK), .nRST(nRST), .bus(ifa)
  );
  t02_mem_arbiter #(.NUM_CH(3), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT_CYC(255)) dut_b (
    .CLK(CLK), .nRST(nRST), .bus(ifb)
  );

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] D0 = 32'hAAAA_5555;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  typedef struct {
    logic        en;
    logic [1:0]  req;
    logic [1:0]  wen;
    logic        busy;
    logic [31:0] ramload;
    logic [1:0]  e_ready;
    logic [1:0]  e_grant;
    logic        e_ren;
    logic        e_wen;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [3:0]  e_sel;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    ifa.en = 1'b0; ifa.req = '0; ifa.wen = '0; ifa.busy_o = 1'b0; ifa.ramload = '0;
    ifa.addr = {A1, A0}; ifa.wdata = {D1, D0}; ifa.sel = {S1, S0};
    ifb.en = 1'b0; ifb.req = '0; ifb.wen = '0; ifb.busy_o = 1'b0; ifb.ramload = '0;
    ifb.addr = {32'h1020, 32'h1010, 32'h1000}; ifb.wdata = '0; ifb.sel = '1;

    //            en  req    wen    bsy ramload        | rdy    gnt    ren  wen  err  rdata          addr store sel
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b01, 2'b00, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b01, 2'b00, 1'b0, 32'hDEADBEEF,  2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b10, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b10, 1'b1, 32'h0,         2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b10, 1'b0, 32'h0BADF00D,  2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF,  A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF,  A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF,  A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 1'b0, 32'h11111111,  2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF,  A0, D0, S0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'h11111111,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h11111111,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b1, 32'h0,         2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 32'h11111111,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b1, 32'h0,         2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 32'h11111111,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b1, 32'h0,         2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 32'h11111111,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b00, 1'b0, 32'h22222222,  2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 32'h11111111,  A1, D1, S1});
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 32'h22222222,  32'h0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h22222222,  32'h0, 32'h0, 4'h0});

    tick();
    chk("rst_ready_a", 0, ifa.ready, 2'b00);
    chk("rst_rdata_a", 0, ifa.rdata, 32'h0);
    chk("rst_ren_a",   0, ifa.Ren,   1'b0);
    chk("rst_grant_b", 0, ifb.grant, 3'b000);
    tick();
    nRST = 1'b1;

    // Single accesses, then fixed-priority contention on channel A.
    for (int i = 0; i < vecs.size(); i++) begin
      ifa.en = vecs[i].en; ifa.req = vecs[i].req; ifa.wen = vecs[i].wen;
      ifa.busy_o = vecs[i].busy; ifa.ramload = vecs[i].ramload;
      #1;
      chk("ready",    i, ifa.ready,    vecs[i].e_ready);
      chk("grant",    i, ifa.grant,    vecs[i].e_grant);
      chk("Ren",      i, ifa.Ren,      vecs[i].e_ren);
      chk("Wen",      i, ifa.Wen,      vecs[i].e_wen);
      chk("err",      i, ifa.err,      vecs[i].e_err);
      chk("rdata",    i, ifa.rdata,    vecs[i].e_rdata);
      chk("ramaddr",  i, ifa.ramaddr,  vecs[i].e_addr);
      chk("ramstore", i, ifa.ramstore, vecs[i].e_store);
      chk("ramsel",   i, ifa.ramsel,   vecs[i].e_sel);
      $display("row %0d: req=%b busy=%b ready=%b grant=%b rdata=%h", i, ifa.req, ifa.busy_o, ifa.ready, ifa.grant, ifa.rdata);
      tick();
    end

    // Timeout: busy_o never rises for a ch0 read.
    ifa.req = 2'b01; ifa.wen = 2'b00; ifa.busy_o = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("to_ren",   c, ifa.Ren,   1'b1);
      chk("to_ready", c, ifa.ready, 2'b00);
      tick();
    end
    chk("to_ready_done", 5, ifa.ready, 2'b01);
    chk("to_err_done",   5, ifa.err,   1'b1);
    chk("to_rdata_done", 5, ifa.rdata, 32'h0);
    chk("to_ren_done",   5, ifa.Ren,   1'b0);
    $display("timeout: ready=%b err=%b rdata=%h", ifa.ready, ifa.err, ifa.rdata);
    ifa.req = 2'b10; ifa.wen = 2'b10;
    tick();
    chk("to_err_idle", 6, ifa.err, 1'b0);
    tick();
    chk("post_to_grant", 7, ifa.grant, 2'b10);
    chk("post_to_wen",   7, ifa.Wen,   1'b1);
    ifa.busy_o = 1'b1;
    tick();
    ifa.busy_o = 1'b0;
    tick();
    chk("post_to_ready", 9, ifa.ready, 2'b10);
    chk("post_to_err",   9, ifa.err,   1'b0);
    chk("post_to_rdata", 9, ifa.rdata, 32'h0);
    $display("post-timeout write: ready=%b err=%b", ifa.ready, ifa.err);
    ifa.req = 2'b00; ifa.wen = 2'b00;
    tick();

    // Round-robin with all three channels requesting continuously.
    ifb.en = 1'b1; ifb.req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("rr_grant", n, ifb.grant, 3'b001 << (n % 3));
      ifb.busy_o = 1'b1;
      tick();
      ifb.busy_o = 1'b0; ifb.ramload = 32'hC0DE_0000 + n;
      tick();
      chk("rr_ready", n, ifb.ready, 3'b001 << (n % 3));
      chk("rr_rdata", n, ifb.rdata, 32'hC0DE_0000 + n);
      $display("rr %0d: ready=%b rdata=%h", n, ifb.ready, ifb.rdata);
      tick();
    end
    ifb.req = 3'b000; ifb.en = 1'b0;

    // Reset during WAIT, then en gating.
    ifa.req = 2'b01; ifa.wen = 2'b00;
    tick();
    ifa.busy_o = 1'b1;
    tick();
    chk("wait_ren",   0, ifa.Ren,   1'b1);
    chk("wait_grant", 0, ifa.grant, 2'b01);
    #2 nRST = 1'b0;
    #1;
    chk("rst_ren",   1, ifa.Ren,   1'b0);
    chk("rst_wen",   1, ifa.Wen,   1'b0);
    chk("rst_grant", 1, ifa.grant, 2'b00);
    chk("rst_ready", 1, ifa.ready, 2'b00);
    @(posedge CLK);
    #2;
    chk("rst_ready_hold", 2, ifa.ready, 2'b00);
    nRST = 1'b1;
    ifa.busy_o = 1'b0; ifa.en = 1'b0; ifa.req = 2'b11;
    tick();
    chk("en0_grant", 0, ifa.grant, 2'b00);
    chk("en0_ready", 0, ifa.ready, 2'b00);
    tick();
    chk("en0_grant", 1, ifa.grant, 2'b00);
    chk("en0_ren",   1, ifa.Ren,   1'b0);
    ifa.en = 1'b1;
    tick();
    chk("en1_grant", 0, ifa.grant, 2'b01);
    chk("en1_ren",   0, ifa.Ren,   1'b1);
    $display("en raised: grant=%b Ren=%b", ifa.grant, ifa.Ren);
    ifa.req = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
